sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 21 ++
 rtl/sram_arbiter_rr_arbiter2.sv | 37 +++
 rtl/sram_arbiter.sv | 134 +++++++++++++
 tb/tb_sram_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared GPU definitions for the SRAM arbiter: FSM states, requester ids
// and the default SRAM geometry.
package sram_arbiter_pkg;

    localparam int DEF_ADDR_W   = 24;
    localparam int DEF_DATA_W   = 1536;
    localparam int DEF_READ_LAT = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    typedef enum logic {
        FILL  = 1'b0,
        ALPHA = 1'b1
    } req_id_t;

endpackage

// File: rtl/sram_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
// The pointer only moves when the caller accepts the grant.
module rr_arbiter2
    import sram_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    fill_req,
    input  logic    alpha_req,
    input  logic    advance,
    output logic    grant_valid,
    output req_id_t grant_id
);

    req_id_t last_reg;

    always_comb begin
        grant_valid = fill_req | alpha_req;
        if (fill_req && alpha_req) begin
            grant_id = (last_reg == FILL) ? ALPHA : FILL;
        end else if (alpha_req) begin
            grant_id = ALPHA;
        end else begin
            grant_id = FILL;
        end
    end

    // Starting from ALPHA lets the fill engine win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= ALPHA;
        end else if (advance && grant_valid) begin
            last_reg <= grant_id;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter between the fill engine (read/write) and the
// alpha blender (read only); one access in flight at a time.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_req,
    input  logic              fill_we,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_wdata,
    output logic              fill_ack,
    input  logic              alpha_req,
    input  logic [ADDR_W-1:0] alpha_addr,
    output logic              alpha_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              read_enable,
    output logic              write_enable,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy
);

    localparam int CNT_W = $clog2(READ_LAT + 1);

    state_t            state_reg, state_next;
    req_id_t           id_reg, id_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              rd_en_reg, rd_en_next;
    logic              wr_en_reg, wr_en_next;
    logic [DATA_W-1:0] rd_data_reg;
    logic              capture;
    logic              grant_valid;
    req_id_t           grant_id;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .fill_req    (fill_req),
        .alpha_req   (alpha_req),
        .advance     (state_reg == IDLE),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        cnt_next   = cnt_reg;
        rd_en_next = 1'b0;
        wr_en_next = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    // Alpha has no write path, so its grant is always a read.
                    id_next    = grant_id;
                    we_next    = (grant_id == FILL) && fill_we;
                    addr_next  = (grant_id == FILL) ? fill_addr : alpha_addr;
                    wdata_next = (grant_id == FILL) ? fill_wdata : '0;
                    rd_en_next = !we_next;
                    wr_en_next = we_next;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = CNT_W'(1);
                state_next = we_reg ? ACK : WAIT;
            end
            WAIT: begin
                // cnt_reg counts cycles since the enable cycle.
                if (cnt_reg == CNT_W'(READ_LAT)) begin
                    capture    = 1'b1;
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            id_reg      <= FILL;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            cnt_reg     <= '0;
            rd_en_reg   <= 1'b0;
            wr_en_reg   <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            id_reg    <= id_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            cnt_reg   <= cnt_next;
            rd_en_reg <= rd_en_next;
            wr_en_reg <= wr_en_next;
            if (capture) begin
                rd_data_reg <= read_data;
            end
        end
    end

    assign read_enable  = rd_en_reg;
    assign write_enable = wr_en_reg;
    assign address      = addr_reg;
    assign write_data   = wdata_reg;
    assign rd_data      = rd_data_reg;
    assign busy         = (state_reg != IDLE);
    assign fill_ack     = (state_reg == ACK) && (id_reg == FILL);
    assign alpha_ack    = (state_reg == ACK) && (id_reg == ALPHA);

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized scoreboard bench for sram_arbiter: requester drivers, an SRAM
// model, and a transaction-level reference model of arbitration and timing.
`timescale 1ns/1ps
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int ADDR_W = DEF_ADDR_W;
    localparam int DATA_W = DEF_DATA_W;
    localparam int L      = DEF_READ_LAT;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef struct {
        logic  we;
        addr_t addr;
        word_t wdata;
        int    gap;
        int    mode;   // 0 normal, 1 drop req during WAIT, 2 abandon (reset test)
    } tx_t;

    typedef struct {
        logic  is_alpha;
        logic  we;
        addr_t addr;
        word_t wdata;
        word_t rdata;
        int    ack_cyc;
    } exp_t;

    typedef struct {
        int    cyc;
        word_t data;
    } resp_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  fill_req, fill_we, fill_ack;
    addr_t fill_addr;
    word_t fill_wdata;
    logic  alpha_req, alpha_ack;
    addr_t alpha_addr;
    word_t rd_data;
    logic  read_enable, write_enable;
    addr_t address;
    word_t write_data;
    word_t read_data;
    logic  busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 0;
    bit fill_active  = 0;
    bit alpha_active = 0;

    tx_t   fill_txq[$], alpha_txq[$];
    tx_t   fill_out[$], alpha_out[$];
    exp_t  exp_q[$];
    resp_t resp_q[$];
    word_t sram_mem[addr_t];
    word_t ref_mem[addr_t];

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .fill_req(fill_req), .fill_we(fill_we), .fill_addr(fill_addr),
        .fill_wdata(fill_wdata), .fill_ack(fill_ack),
        .alpha_req(alpha_req), .alpha_addr(alpha_addr), .alpha_ack(alpha_ack),
        .rd_data(rd_data), .read_enable(read_enable), .write_enable(write_enable),
        .address(address), .write_data(write_data), .read_data(read_data),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input word_t act, input word_t want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (low 64 bits)", name, act[63:0], want[63:0]);
        end
    endtask

    // Power-up SRAM contents; 0x00ABCD holds the 0x1234 pattern.
    function automatic word_t init_word(input addr_t a);
        word_t w;
        if (a == 24'h00ABCD) begin
            w = {96{16'h1234}};
        end else begin
            for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = {8'(i), a} ^ 32'h9E3779B9;
        end
        return w;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // SRAM model: writes land at the enable cycle, read data appears only
    // in cycle E+L; garbage is driven on every other cycle.
    initial begin : sram_model
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (write_enable) sram_mem[address] = write_data;
                if (read_enable)
                    resp_q.push_back('{cyc + L, sram_mem.exists(address) ? sram_mem[address] : init_word(address)});
            end
        end
    end

    initial begin : sram_drive
        resp_t r;
        read_data = '0;
        forever begin
            @(posedge clk); #1;
            if (resp_q.size() != 0 && resp_q[0].cyc == cyc) begin
                r = resp_q.pop_front();
                read_data = r.data;
            end else begin
                read_data = rand_word();
            end
        end
    end

    task automatic wait_ack(input bit is_alpha);
        bit got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = is_alpha ? alpha_ack : fill_ack;
        end
        check(is_alpha ? "alpha_ack_timeout" : "fill_ack_timeout", got, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin : fill_drv
        tx_t t;
        fill_req = 0; fill_we = 0; fill_addr = '0; fill_wdata = '0;
        @(posedge clk); #1;
        forever begin
            if (fill_txq.size() == 0) begin
                fill_req = 0; fill_active = 0;
                @(posedge clk); #1;
            end else begin
                fill_active = 1;
                t = fill_txq.pop_front();
                if (t.gap > 0) begin
                    fill_req = 0;
                    repeat (t.gap) begin @(posedge clk); #1; end
                end
                fill_req = 1; fill_we = t.we; fill_addr = t.addr; fill_wdata = t.wdata;
                if (t.mode == 2) begin
                    repeat (3) begin @(posedge clk); #1; end
                    fill_req = 0;
                end else begin
                    fill_out.push_back(t);
                    if (t.mode == 1) begin
                        repeat (2) begin @(posedge clk); #1; end
                        fill_req = 0;
                    end
                    wait_ack(1'b0);
                end
            end
        end
    end

    initial begin : alpha_drv
        tx_t t;
        alpha_req = 0; alpha_addr = '0;
        @(posedge clk); #1;
        forever begin
            if (alpha_txq.size() == 0) begin
                alpha_req = 0; alpha_active = 0;
                @(posedge clk); #1;
            end else begin
                alpha_active = 1;
                t = alpha_txq.pop_front();
                if (t.gap > 0) begin
                    alpha_req = 0;
                    repeat (t.gap) begin @(posedge clk); #1; end
                end
                alpha_req = 1; alpha_addr = t.addr;
                alpha_out.push_back(t);
                wait_ack(1'b1);
            end
        end
    end

    // Reference model: decides grants from the requests seen in an idle cycle
    // and predicts strobes, busy, ack cycle and read data for each access.
    initial begin : monitor
        exp_t pend, e;
        tx_t  t;
        bit   pend_v = 0, last_alpha = 1, win_alpha, have;
        int   pend_cyc = 0, free_cyc = 0, c;
        forever begin
            @(negedge clk);
            c = cyc;
            if (rst) last_alpha = 1;
            if (rst || !mon_en) begin
                pend_v = 0;
                free_cyc = c + 1;
            end else begin
                check("busy", busy, c >= free_cyc ? 1'b0 : 1'b1);
                check("strobe_excl", read_enable & write_enable, 1'b0);
                if (pend_v && pend_cyc == c) begin
                    check("read_enable", read_enable, !pend.we);
                    check("write_enable", write_enable, pend.we);
                    check("address", address, pend.addr);
                    if (pend.we) check("write_data", write_data, pend.wdata);
                    pend_v = 0;
                end else begin
                    check("no_strobe", {read_enable, write_enable}, 2'b00);
                end
                if (fill_ack || alpha_ack) begin
                    check("single_ack", fill_ack & alpha_ack, 1'b0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", {fill_ack, alpha_ack}, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_id", {fill_ack, alpha_ack}, e.is_alpha ? 2'b01 : 2'b10);
                        check("ack_cycle", c, e.ack_cyc);
                        if (!e.we) check("rd_data", rd_data, e.rdata);
                        $display("txn %s %s addr=0x%06h ack_cyc=%0d", e.is_alpha ? "alpha" : "fill",
                                 e.we ? "write" : "read", e.addr, c);
                    end
                end else if (exp_q.size() != 0 && exp_q[0].ack_cyc <= c) begin
                    e = exp_q.pop_front();
                    check("missing_ack", {fill_ack, alpha_ack}, e.is_alpha ? 2'b01 : 2'b10);
                end
                if (c >= free_cyc && (fill_req || alpha_req)) begin
                    win_alpha = (fill_req && alpha_req) ? !last_alpha : alpha_req;
                    have = win_alpha ? (alpha_out.size() != 0) : (fill_out.size() != 0);
                    if (have) begin
                        t = win_alpha ? alpha_out.pop_front() : fill_out.pop_front();
                        pend.is_alpha = win_alpha;
                        pend.we       = win_alpha ? 1'b0 : t.we;
                        pend.addr     = t.addr;
                        pend.wdata    = t.wdata;
                        pend.rdata    = '0;
                        if (pend.we) begin
                            ref_mem[t.addr] = t.wdata;
                            pend.ack_cyc = c + 2;
                            free_cyc     = c + 3;
                        end else begin
                            pend.rdata   = ref_mem.exists(t.addr) ? ref_mem[t.addr] : init_word(t.addr);
                            pend.ack_cyc = c + L + 2;
                            free_cyc     = c + L + 3;
                        end
                        pend_v = 1; pend_cyc = c + 1;
                        exp_q.push_back(pend);
                        last_alpha = win_alpha;
                    end
                end
            end
        end
    end

    task automatic push_fill(input logic we, input addr_t a, input word_t d, input int gap, input int mode);
        tx_t t;
        t.we = we; t.addr = a; t.wdata = d; t.gap = gap; t.mode = mode;
        fill_txq.push_back(t);
    endtask

    task automatic push_alpha(input addr_t a, input int gap);
        tx_t t;
        t.we = 1'b0; t.addr = a; t.wdata = '0; t.gap = gap; t.mode = 0;
        alpha_txq.push_back(t);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((fill_txq.size() != 0 || alpha_txq.size() != 0 || fill_active || alpha_active
                || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n < 3000, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_read_enable"}, read_enable, 1'b0);
        check({tag, "_write_enable"}, write_enable, 1'b0);
        check({tag, "_address"}, address, '0);
        check({tag, "_write_data"}, write_data, '0);
        check({tag, "_fill_ack"}, fill_ack, 1'b0);
        check({tag, "_alpha_ack"}, alpha_ack, 1'b0);
        check({tag, "_rd_data"}, rd_data, '0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no finish, expected finish before 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_outputs_zero("por");
        rst = 1'b0;
        mon_en = 1;

        // Tie after reset: fill first, then alpha beats fill's back-to-back request.
        push_fill(1'b0, 24'h000200, '0, 0, 0);
        push_fill(1'b0, 24'h000201, '0, 0, 0);
        push_alpha(24'h000300, 0);
        wait_idle();

        push_fill(1'b1, 24'h000010, {192{8'hA5}}, 0, 0);
        wait_idle();
        push_alpha(24'h00ABCD, 0);
        wait_idle();
        push_fill(1'b0, 24'h000123, '0, 0, 1);
        wait_idle();
        for (int i = 0; i < 5; i++) push_alpha(addr_t'(24'h000400 + i), 0);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            push_fill(1'($urandom_range(0, 1)), addr_t'(24'h000100 + $urandom_range(0, 7)),
                      rand_word(), $urandom_range(0, 3), 0);
            push_alpha(addr_t'(24'h000100 + $urandom_range(0, 7)), $urandom_range(0, 3));
        end
        wait_idle();

        // Reset in the middle of a read's WAIT: access is abandoned silently.
        mon_en = 0;
        push_fill(1'b0, 24'h000777, '0, 0, 2);
        n = 0;
        while (!read_enable && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_issue", read_enable, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_rst");
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_outputs_zero("post_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
